// File: rtl/collective_router_top.sv
// collective_router_top
// Reduction/combining endpoint of the MPI collective router. Reduction
// contributions are folded per slot (selected by the low tag bits); once a
// slot has NUM_CONTRIB contributions a single combined packet is emitted.
// Non-reduction opcodes pass through unchanged and NOPs are dropped.
// All outputs are registered: an input sampled at edge N produces its
// output after edge N, visible for exactly one cycle.

module collective_router_top #(
  parameter int NUM_CONTRIB = 3,
  parameter int SLOT_BITS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  dst_z,
  input  logic [2:0]  dst_y,
  input  logic [2:0]  dst_x,
  input  logic [2:0]  src_z,
  input  logic [2:0]  src_y,
  input  logic [2:0]  src_x,
  input  logic [7:0]  contextId,
  input  logic [7:0]  tag,
  input  logic [1:0]  algtype,
  input  logic [3:0]  op,
  input  logic [31:0] payload,
  output logic [72:0] Outpacket,
  output logic        done,
  output logic        valid_out
);

  localparam int unsigned NUM_SLOTS      = 1 << SLOT_BITS;
  localparam logic [3:0]  CONTRIB_TARGET = 4'(NUM_CONTRIB);

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_SUM     = 4'h1,
    OP_MAX     = 4'h2,
    OP_MIN     = 4'h3,
    OP_AND     = 4'h4,
    OP_OR      = 4'h5,
    OP_XOR     = 4'h6,
    OP_PROD    = 4'h7,
    OP_SUM_ALT = 4'hF
  } opcode_e;

  // Per-slot reduction state
  logic [3:0]  slot_count [NUM_SLOTS];
  logic [31:0] slot_acc   [NUM_SLOTS];
  logic [3:0]  slot_op    [NUM_SLOTS];

  // Datapath intermediates
  logic [SLOT_BITS-1:0] sel;
  logic                 is_red;
  logic                 is_pass;
  logic                 slot_empty;
  logic [3:0]           cur_count;
  logic [3:0]           new_count;
  logic [3:0]           eff_op;
  logic [31:0]          red_result;
  logic                 complete;
  logic [35:0]          header;
  logic [72:0]          pkt_d;
  logic                 done_d;

  // Two-operand combine for one latched opcode
  function automatic logic [31:0] combine(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  o);
    logic [31:0] r;
    r = a;
    case (o)
      OP_SUM, OP_SUM_ALT: r = a + b;
      OP_MAX:             r = (a > b) ? a : b;
      OP_MIN:             r = (a < b) ? a : b;
      OP_AND:             r = a & b;
      OP_OR:              r = a | b;
      OP_XOR:             r = a ^ b;
      OP_PROD:            r = a * b;
      default:            r = a;
    endcase
    return r;
  endfunction

  // Opcode classification
  always_comb begin
    is_red  = 1'b0;
    is_pass = 1'b0;
    case (op)
      OP_NOP: begin
        is_red  = 1'b0;
        is_pass = 1'b0;
      end
      OP_SUM, OP_MAX, OP_MIN, OP_AND, OP_OR, OP_XOR, OP_PROD, OP_SUM_ALT:
        is_red = 1'b1;
      default:
        is_pass = 1'b1;
    endcase
  end

  // Slot lookup, fold and completion detection
  always_comb begin
    sel        = tag[SLOT_BITS-1:0];
    cur_count  = slot_count[sel];
    slot_empty = (cur_count == 4'd0);
    // An empty slot takes the incoming op; otherwise the latched op rules
    eff_op     = slot_empty ? op : slot_op[sel];
    red_result = slot_empty ? payload : combine(slot_acc[sel], payload, eff_op);
    new_count  = slot_empty ? 4'd1 : cur_count + 4'd1;
    complete   = valid_in && is_red && (new_count == CONTRIB_TARGET);
  end

  // Next output packet: pass-through, completed reduction, or idle zero
  always_comb begin
    header = {dst_z, dst_y, dst_x, src_z, src_y, src_x, contextId, tag, algtype};
    pkt_d  = '0;
    done_d = 1'b0;
    if (valid_in && is_pass) begin
      pkt_d = {1'b1, header, op, payload};
    end else if (complete) begin
      pkt_d  = {1'b1, header, eff_op, red_result};
      done_d = 1'b1;
    end
  end

  // Slot state update; a completing slot returns to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_count[i] <= '0;
        slot_acc[i]   <= '0;
        slot_op[i]    <= '0;
      end
    end else if (valid_in && is_red) begin
      if (complete) begin
        slot_count[sel] <= '0;
        slot_acc[sel]   <= '0;
        slot_op[sel]    <= '0;
      end else begin
        slot_count[sel] <= new_count;
        slot_acc[sel]   <= red_result;
        slot_op[sel]    <= eff_op;
      end
    end
  end

  // Registered output packet and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Outpacket <= '0;
      done      <= 1'b0;
    end else begin
      Outpacket <= pkt_d;
      done      <= done_d;
    end
  end

  assign valid_out = Outpacket[72];

endmodule

// File: tb/tb_collective_router_top.sv
// Directed scoreboard bench for collective_router_top.
module tb_collective_router_top;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [2:0]  dst_z, dst_y, dst_x;
  logic [2:0]  src_z, src_y, src_x;
  logic [7:0]  contextId;
  logic [7:0]  tag;
  logic [1:0]  algtype;
  logic [3:0]  op;
  logic [31:0] payload;
  logic [72:0] Outpacket;
  logic        done;
  logic        valid_out;

  typedef struct {
    logic [72:0] pkt;
    logic        done;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_assert;
  int   n_fail;

  collective_router_top #(.NUM_CONTRIB(3), .SLOT_BITS(1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .dst_z(dst_z), .dst_y(dst_y), .dst_x(dst_x),
    .src_z(src_z), .src_y(src_y), .src_x(src_x),
    .contextId(contextId), .tag(tag), .algtype(algtype),
    .op(op), .payload(payload),
    .Outpacket(Outpacket), .done(done), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_hdr(input logic [2:0] dx, input logic [7:0] ctx, input logic [1:0] alg);
    dst_z = 3'd0; dst_y = 3'd0; dst_x = dx;
    src_z = 3'd0; src_y = 3'd0; src_x = 3'd1;
    contextId = ctx; algtype = alg;
  endtask

  // Pop one expected entry and compare against the current outputs
  task automatic check_out();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (Outpacket === e.pkt) else begin
        n_fail++;
        $error("FAIL %s pkt: observed %h expected %h", e.name, Outpacket, e.pkt);
      end
      n_assert++;
      assert (done === e.done) else begin
        n_fail++;
        $error("FAIL %s done: observed %b expected %b", e.name, done, e.done);
      end
      n_assert++;
      assert (valid_out === e.pkt[72]) else begin
        n_fail++;
        $error("FAIL %s valid_out: observed %b expected %b", e.name, valid_out, e.pkt[72]);
      end
    end
  endtask

  task automatic expect_idle(input string nm);
    exp_t e;
    e.pkt = '0; e.done = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive one input, push the expected output, clock, then compare
  task automatic step(input logic vi, input logic [3:0] o, input logic [7:0] t,
                      input logic [31:0] p, input logic ev, input logic ed,
                      input logic [3:0] eop, input logic [31:0] epl, input string nm);
    exp_t e;
    valid_in = vi; op = o; tag = t; payload = p;
    e.pkt  = ev ? {1'b1, dst_z, dst_y, dst_x, src_z, src_y, src_x,
                   contextId, t, algtype, eop, epl} : 73'd0;
    e.done = ed;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [72:0] lit_pkt;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_hdr(3'd0, 8'h00, 2'b00);
    src_x = 3'd0;

    // Reset held with valid NOP traffic
    for (int i = 0; i < 10; i++) step(1'b1, 4'h0, 8'h00, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, "reset_hold");
    rst = 1'b0;
    step(1'b1, 4'h0, 8'h00, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, "post_reset_nop0");
    step(1'b1, 4'h0, 8'h01, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "post_reset_nop1");

    // Interleaved SUM on tags 1 and 0
    set_hdr(3'd0, 8'h00, 2'b00);
    step(1'b1, 4'hF, 8'h01, 32'd6, 1'b0, 1'b0, 4'h0, 32'd0, "isum_6");
    step(1'b1, 4'hF, 8'h00, 32'd5, 1'b0, 1'b0, 4'h0, 32'd0, "isum_5");
    step(1'b1, 4'hF, 8'h01, 32'd4, 1'b0, 1'b0, 4'h0, 32'd0, "isum_4");
    step(1'b1, 4'hF, 8'h00, 32'd3, 1'b0, 1'b0, 4'h0, 32'd0, "isum_3");
    step(1'b1, 4'hF, 8'h01, 32'd2, 1'b1, 1'b1, 4'hF, 32'd12, "isum_tag1");
    lit_pkt = {1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 8'h00, 8'h01, 2'b00, 4'hF, 32'd12};
    n_assert++;
    assert (Outpacket === lit_pkt) else begin
      n_fail++;
      $error("FAIL isum_literal: observed %h expected %h", Outpacket, lit_pkt);
    end
    step(1'b1, 4'hF, 8'h00, 32'd1, 1'b1, 1'b1, 4'hF, 32'd9, "isum_tag0");

    // Continuation
    step(1'b1, 4'hF, 8'h01, 32'd6, 1'b0, 1'b0, 4'h0, 32'd0, "cont_6");
    step(1'b1, 4'hF, 8'h00, 32'd5, 1'b0, 1'b0, 4'h0, 32'd0, "cont_5");
    step(1'b1, 4'hF, 8'h01, 32'd4, 1'b0, 1'b0, 4'h0, 32'd0, "cont_4");
    step(1'b1, 4'hF, 8'h01, 32'd1, 1'b1, 1'b1, 4'hF, 32'd11, "cont_tag1");
    step(1'b1, 4'hF, 8'h00, 32'd1, 1'b0, 1'b0, 4'h0, 32'd0, "drain_1");
    step(1'b1, 4'hF, 8'h00, 32'd1, 1'b1, 1'b1, 4'hF, 32'd7, "drain_tag0");

    // Operators on tag 0; completing header differs to show it is taken from that input
    step(1'b1, 4'h2, 8'h00, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "max_a");
    step(1'b1, 4'h2, 8'h00, 32'd2, 1'b0, 1'b0, 4'h0, 32'd0, "max_b");
    set_hdr(3'd3, 8'hA5, 2'b10);
    step(1'b1, 4'h2, 8'h00, 32'd9, 1'b1, 1'b1, 4'h2, 32'd9, "max");
    set_hdr(3'd0, 8'h00, 2'b00);
    // Later contributions carry other ops; the latched MIN must be used
    step(1'b1, 4'h3, 8'h00, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "min_a");
    step(1'b1, 4'h1, 8'h00, 32'd2, 1'b0, 1'b0, 4'h0, 32'd0, "min_b");
    step(1'b1, 4'h6, 8'h00, 32'd9, 1'b1, 1'b1, 4'h3, 32'd2, "min");
    step(1'b1, 4'h6, 8'h00, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "xor_a");
    step(1'b1, 4'h6, 8'h00, 32'd2, 1'b0, 1'b0, 4'h0, 32'd0, "xor_b");
    step(1'b1, 4'h6, 8'h00, 32'd9, 1'b1, 1'b1, 4'h6, 32'd12, "xor");
    step(1'b1, 4'h7, 8'h00, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "prod_a");
    step(1'b1, 4'h7, 8'h00, 32'd2, 1'b0, 1'b0, 4'h0, 32'd0, "prod_b");
    step(1'b1, 4'h7, 8'h00, 32'd9, 1'b1, 1'b1, 4'h7, 32'd126, "prod");
    step(1'b1, 4'h4, 8'h00, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "and_a");
    step(1'b1, 4'h4, 8'h00, 32'd2, 1'b0, 1'b0, 4'h0, 32'd0, "and_b");
    step(1'b1, 4'h4, 8'h00, 32'd9, 1'b1, 1'b1, 4'h4, 32'd0, "and");
    step(1'b1, 4'h5, 8'h00, 32'd7, 1'b0, 1'b0, 4'h0, 32'd0, "or_a");
    step(1'b1, 4'h5, 8'h00, 32'd2, 1'b0, 1'b0, 4'h0, 32'd0, "or_b");
    step(1'b1, 4'h5, 8'h00, 32'd9, 1'b1, 1'b1, 4'h5, 32'd15, "or");
    step(1'b1, 4'h1, 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'd0, "sumwrap_a");
    step(1'b1, 4'h1, 8'h00, 32'd1, 1'b0, 1'b0, 4'h0, 32'd0, "sumwrap_b");
    step(1'b1, 4'h1, 8'h00, 32'd1, 1'b1, 1'b1, 4'h1, 32'd1, "sumwrap");

    // Pass-through, NOP and idle around a partial slot-0 reduction
    step(1'b1, 4'h1, 8'h00, 32'd10, 1'b0, 1'b0, 4'h0, 32'd0, "part_10");
    step(1'b0, 4'h1, 8'h00, 32'd99, 1'b0, 1'b0, 4'h0, 32'd0, "idle_invalid");
    step(1'b1, 4'h8, 8'h00, 32'd5, 1'b1, 1'b0, 4'h8, 32'd5, "pass_8");
    step(1'b1, 4'hE, 8'h01, 32'd7, 1'b1, 1'b0, 4'hE, 32'd7, "pass_E");
    step(1'b1, 4'h0, 8'h00, 32'd1, 1'b0, 1'b0, 4'h0, 32'd0, "nop");
    step(1'b1, 4'h1, 8'h02, 32'd1, 1'b0, 1'b0, 4'h0, 32'd0, "part_hi_tag");
    step(1'b1, 4'h1, 8'h01, 32'd5, 1'b0, 1'b0, 4'h0, 32'd0, "rst_part_a");
    step(1'b1, 4'h1, 8'h01, 32'd5, 1'b0, 1'b0, 4'h0, 32'd0, "rst_part_b");
    step(1'b1, 4'h1, 8'h02, 32'd1, 1'b1, 1'b1, 4'h1, 32'd12, "part_done");

    // Asynchronous reset clears the visible output and slot 1's partial sum
    rst = 1'b1;
    #1;
    expect_idle("async_reset");
    check_out();
    step(1'b1, 4'h1, 8'h01, 32'd100, 1'b0, 1'b0, 4'h0, 32'd0, "reset_ignore");
    rst = 1'b0;
    step(1'b1, 4'h1, 8'h01, 32'd1, 1'b0, 1'b0, 4'h0, 32'd0, "after_rst_a");
    step(1'b1, 4'h1, 8'h01, 32'd1, 1'b0, 1'b0, 4'h0, 32'd0, "after_rst_b");
    step(1'b1, 4'h1, 8'h01, 32'd1, 1'b1, 1'b1, 4'h1, 32'd3, "after_rst");
    step(1'b0, 4'h0, 8'h00, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
